// File: rtl/conv_layer_ctrl_if.sv
// Handshake and memory-control bundle between the conv layer controller
// and the outside world (x stream, y stream, x/filter memories, accumulator).
interface conv_layer_ctrl_if #(
    parameter int N = 16,
    parameter int M = 4
);
    localparam int AW_X = $clog2(N);
    localparam int AW_F = $clog2(M);

    logic            s_valid_x;
    logic            s_ready_x;
    logic            m_valid_y;
    logic            m_ready_y;
    logic [AW_X-1:0] addr_x;
    logic            wr_en_x;
    logic [AW_F-1:0] addr_f;
    logic            en_acc;
    logic            clear_acc;

    modport master (
        input  s_valid_x,
        input  m_ready_y,
        output s_ready_x,
        output m_valid_y,
        output addr_x,
        output wr_en_x,
        output addr_f,
        output en_acc,
        output clear_acc
    );

    modport slave (
        output s_valid_x,
        output m_ready_y,
        input  s_ready_x,
        input  m_valid_y,
        input  addr_x,
        input  wr_en_x,
        input  addr_f,
        input  en_acc,
        input  clear_acc
    );
endinterface

// File: rtl/conv_layer_ctrl.sv
// Sequencer for a 1-D valid convolution: loads N x values, then issues M taps
// per output and hands each finished accumulator value downstream.
//
// state   | meaning
// --------+-----------------------------------------------------------
// LOAD    | accept x values into x-memory, address = load count
// COMPUTE | issue one tap per cycle, addr_x = o+t, addr_f = t
// FLUSH   | one cycle for the last delayed en_acc to land
// OUT     | accumulator holds y; wait for downstream handshake
module conv_layer_ctrl #(
    parameter int N = 16,
    parameter int M = 4,
    parameter int T = 16
) (
    input  logic              clk,
    input  logic              reset,
    conv_layer_ctrl_if.master bus
);
    localparam int AW_X = $clog2(N);
    localparam int AW_F = $clog2(M);
    localparam int P    = N - M + 1;

    localparam logic [AW_X-1:0] LD_LAST = AW_X'(N - 1);
    localparam logic [AW_F-1:0] T_LAST  = AW_F'(M - 1);
    localparam logic [AW_X-1:0] O_LAST  = AW_X'(P - 1);

    if (N < 2 || M < 2 || M > N || T < 1) begin : g_param_check
        $error("conv_layer_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        FLUSH   = 2'd2,
        OUT     = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW_X-1:0] ld;
    logic [AW_X-1:0] ld_nxt;
    logic [AW_X-1:0] o;
    logic [AW_X-1:0] o_nxt;
    logic [AW_F-1:0] t;
    logic [AW_F-1:0] t_nxt;
    logic            issue;
    logic            en_q;
    logic            clr_q;

    logic            s_ready_c;
    logic            wr_en_c;
    logic            m_valid_c;
    logic [AW_X-1:0] addr_x_c;
    logic [AW_F-1:0] addr_f_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
            ld    <= '0;
            o     <= '0;
            t     <= '0;
            en_q  <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            state <= state_nxt;
            ld    <= ld_nxt;
            o     <= o_nxt;
            t     <= t_nxt;
            // Memory reads take one cycle, so accumulator strobes trail the issue.
            en_q  <= issue;
            clr_q <= issue && (t == '0);
        end
    end

    always_comb begin
        state_nxt = state;
        ld_nxt    = ld;
        o_nxt     = o;
        t_nxt     = t;
        issue     = 1'b0;
        s_ready_c = 1'b0;
        wr_en_c   = 1'b0;
        m_valid_c = 1'b0;
        addr_x_c  = o + AW_X'(t);
        addr_f_c  = t;

        unique case (state)
            LOAD: begin
                s_ready_c = 1'b1;
                wr_en_c   = bus.s_valid_x;
                addr_x_c  = ld;
                addr_f_c  = '0;
                if (bus.s_valid_x) begin
                    if (ld == LD_LAST) begin
                        ld_nxt    = '0;
                        o_nxt     = '0;
                        t_nxt     = '0;
                        state_nxt = COMPUTE;
                    end else begin
                        ld_nxt = ld + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                issue = 1'b1;
                if (t == T_LAST) begin
                    state_nxt = FLUSH;
                end else begin
                    t_nxt = t + 1'b1;
                end
            end
            FLUSH: begin
                state_nxt = OUT;
            end
            OUT: begin
                m_valid_c = 1'b1;
                if (bus.m_ready_y) begin
                    t_nxt = '0;
                    if (o == O_LAST) begin
                        o_nxt     = '0;
                        state_nxt = LOAD;
                    end else begin
                        o_nxt     = o + 1'b1;
                        state_nxt = COMPUTE;
                    end
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // Outputs are forced quiet during the reset cycle itself, not only after it.
    assign bus.s_ready_x = s_ready_c && !reset;
    assign bus.wr_en_x   = wr_en_c && !reset;
    assign bus.m_valid_y = m_valid_c && !reset;
    assign bus.addr_x    = reset ? '0 : addr_x_c;
    assign bus.addr_f    = reset ? '0 : addr_f_c;
    assign bus.en_acc    = en_q && !reset;
    assign bus.clear_acc = clr_q && en_q && !reset;
endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Bench for conv_layer_ctrl: a behavioural x/filter memory and accumulator
// driven by the controller, with expected y values queued from the loaded data.
module tb_conv_layer_ctrl;
    localparam int N = 16;
    localparam int M = 4;
    localparam int T = 16;
    localparam int P = N - M + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [T-1:0] x_data = '0;

    conv_layer_ctrl_if #(.N(N), .M(M)) bus ();

    conv_layer_ctrl #(.N(N), .M(M), .T(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int nw = 0;
    int ny = 0;
    int wr_cnt = 0;

    logic [T-1:0]  xmem [N];
    logic [T-1:0]  fmem [M];
    logic [T-1:0]  xrd;
    logic [T-1:0]  frd;
    logic [63:0]   acc;
    logic [T-1:0]  xq [$];
    logic [63:0]   yq [$];

    bit           vx;
    bit           ry;
    bit           rs;
    logic [T-1:0] dx;

    // Golden datapath: 1-cycle read latency memories feeding a MAC.
    always @(posedge clk) begin
        if (bus.wr_en_x) xmem[bus.addr_x] <= x_data;
        xrd <= xmem[bus.addr_x];
        frd <= fmem[bus.addr_f];
        if (bus.en_acc)
            acc <= bus.clear_acc ? 64'(xrd) * 64'(frd) : acc + 64'(xrd) * 64'(frd);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs after the falling edge, then score the outputs.
    task automatic cycle();
        logic [63:0] y;
        @(negedge clk);
        reset         = rs;
        bus.s_valid_x = vx;
        bus.m_ready_y = ry;
        x_data        = dx;
        #1;
        if (!rs) begin
            if (vx) chk("wr_en", 64'(bus.wr_en_x), 64'(bus.s_ready_x));
            if (bus.wr_en_x) begin
                chk("wr_addr", 64'(bus.addr_x), 64'(wr_cnt));
                xq.push_back(dx);
                nw++;
                wr_cnt++;
                if (wr_cnt == N) begin
                    for (int k = 0; k < P; k++) begin
                        y = '0;
                        for (int j = 0; j < M; j++) y += 64'(xq[k+j]) * 64'(fmem[j]);
                        yq.push_back(y);
                    end
                    wr_cnt = 0;
                    xq.delete();
                end
            end
            if (bus.m_valid_y && bus.m_ready_y) begin
                chk("y_avail", 64'(yq.size() > 0), 64'(1));
                if (yq.size() > 0) chk("y", acc, yq.pop_front());
                ny++;
            end
        end
    endtask

    task automatic run(input int wr_goal, input int y_goal, input bit rnd_x,
                       input bit rnd_y, input string tag);
        int n;
        n = 0;
        while ((nw < wr_goal || ny < y_goal) && n < 3000) begin
            vx = rnd_x ? 1'($urandom_range(0, 1)) : (nw < wr_goal);
            ry = rnd_y ? 1'($urandom_range(0, 1)) : 1'b1;
            dx = T'($urandom);
            cycle();
            n++;
        end
        chk({tag, "_writes"}, 64'(nw), 64'(wr_goal));
        chk({tag, "_outputs"}, 64'(ny), 64'(y_goal));
    endtask

    task automatic pulse_reset(input string tag);
        rs = 1'b1; vx = 1'b1; ry = 1'b1; dx = T'($urandom);
        cycle();
        chk({tag, "_rst_s_ready"}, 64'(bus.s_ready_x), 64'(0));
        chk({tag, "_rst_wr_en"},   64'(bus.wr_en_x),   64'(0));
        chk({tag, "_rst_m_valid"}, 64'(bus.m_valid_y), 64'(0));
        chk({tag, "_rst_en_acc"},  64'(bus.en_acc),    64'(0));
        chk({tag, "_rst_clear"},   64'(bus.clear_acc), 64'(0));
        chk({tag, "_rst_addr_x"},  64'(bus.addr_x),    64'(0));
        chk({tag, "_rst_addr_f"},  64'(bus.addr_f),    64'(0));
        rs = 1'b0;
        wr_cnt = 0;
        xq.delete();
        yq.delete();
        vx = 1'b0;
        cycle();
        chk({tag, "_post_s_ready"}, 64'(bus.s_ready_x), 64'(1));
        chk({tag, "_post_m_valid"}, 64'(bus.m_valid_y), 64'(0));
        chk({tag, "_post_en_acc"},  64'(bus.en_acc),    64'(0));
    endtask

    initial begin
        int exp_a;
        for (int j = 0; j < M; j++) fmem[j] = T'($urandom);
        bus.s_valid_x = 1'b0;
        bus.m_ready_y = 1'b0;
        rs = 1'b0; vx = 1'b0; ry = 1'b0; dx = '0;

        pulse_reset("init");

        // Straight load, then a stalled first output with stray x strobes.
        nw = 0; ny = 0;
        run(N, 0, 1'b0, 1'b0, "load");
        for (int c = 0; c < 16; c++) begin
            vx = (c == 2 || c == 8);
            ry = (c == 15);
            dx = T'($urandom);
            cycle();
            exp_a = (c < M - 1) ? c : M - 1;
            chk("dir_s_ready", 64'(bus.s_ready_x), 64'(0));
            chk("dir_wr_en",   64'(bus.wr_en_x),   64'(0));
            chk("dir_addr_x",  64'(bus.addr_x),    64'(exp_a));
            chk("dir_addr_f",  64'(bus.addr_f),    64'(exp_a));
            chk("dir_en_acc",  64'(bus.en_acc),    64'(c >= 1 && c <= M));
            chk("dir_clear",   64'(bus.clear_acc), 64'(c == 1));
            chk("dir_m_valid", 64'(bus.m_valid_y), 64'(c >= M + 1));
        end
        vx = 1'b0; ry = 1'b1;
        cycle();
        chk("dir_o1_addr_x", 64'(bus.addr_x), 64'(1));
        chk("dir_o1_addr_f", 64'(bus.addr_f), 64'(0));
        chk("dir_o1_m_valid", 64'(bus.m_valid_y), 64'(0));
        run(N, P, 1'b0, 1'b0, "dir");
        vx = 1'b0; ry = 1'b0;
        cycle();
        chk("dir_reload_ready", 64'(bus.s_ready_x), 64'(1));
        chk("dir_yq_empty", 64'(yq.size()), 64'(0));

        // Randomised valid/ready over a full run.
        nw = 0; ny = 0;
        run(N, P, 1'b1, 1'b1, "rnd");
        vx = 1'b0; ry = 1'b0;
        cycle();
        chk("rnd_reload_ready", 64'(bus.s_ready_x), 64'(1));
        chk("rnd_yq_empty", 64'(yq.size()), 64'(0));

        // Reset during COMPUTE of output 5, then a fresh run.
        nw = 0; ny = 0;
        run(N, 5, 1'b0, 1'b0, "pre");
        vx = 1'b0; ry = 1'b1;
        cycle();
        chk("mid_addr_x", 64'(bus.addr_x), 64'(5));
        cycle();
        chk("mid_addr_x2", 64'(bus.addr_x), 64'(6));
        pulse_reset("mid");
        nw = 0; ny = 0;
        run(N, P, 1'b1, 1'b1, "post");
        chk("post_yq_empty", 64'(yq.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
